// File: rtl/mod_p_stream.sv
// mod_p_stream: streaming multi-lane mod-P reducer with a runtime-loadable
// D x K reduction matrix, a single-slot registered output stage, and
// CHECK-mode codeword error accounting (per-frame count and sticky alarm).
module mod_p_stream #(
  parameter int K         = 8,
  parameter int D         = 8,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*(K+D)-1:0]                 in_data,
  input  logic                                   mode,
  input  logic                                   b_we,
  input  logic [$clog2(D)-1:0]                   b_waddr,
  input  logic [K-1:0]                           b_wdata,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*K-1:0]                     out_data,
  output logic                                   out_last,
  output logic                                   out_err,
  output logic                                   frame_done,
  output logic [$clog2(FRAME_LEN*LANES+1)-1:0]   frame_err_cnt,
  output logic                                   alarm,
  input  logic                                   alarm_clr
);

  localparam int W  = K + D;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(FRAME_LEN*LANES+1);
  localparam int PW = $clog2(LANES+1);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  // r[i] = x[i] ^ XOR_j (B[j][i] & y[j])
  function automatic logic [K-1:0] reduce_word(
    input logic [K-1:0]        x,
    input logic [D-1:0]        y,
    input logic [D-1:0][K-1:0] b
  );
    logic [K-1:0] r;
    r = x;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < D; j++) begin
        r[i] = r[i] ^ (b[j][i] & y[j]);
      end
    end
    return r;
  endfunction

  // Number of lanes flagged nonzero in one beat
  function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int l = 0; l < LANES; l++) begin
      n = n + PW'(v[l]);
    end
    return n;
  endfunction

  // Reduction matrix, one K-bit row per redundancy bit
  logic [D-1:0][K-1:0] b_q;

  // Frame sequencing
  logic [BW-1:0] beat_q, beat_d;
  logic          mode_q, mode_d;
  logic          last_d;

  // Output slot
  logic               out_valid_q;
  logic [LANES*K-1:0] out_data_q;
  logic               out_last_q;
  logic               out_err_q;
  logic [PW-1:0]      beat_nz_q;

  // Error accounting
  logic [CW-1:0] acc_q;
  logic [CW-1:0] acc_d;
  logic [CW-1:0] frame_err_cnt_q;
  logic          frame_done_q;
  logic          alarm_q;

  // Per-beat combinational results
  logic               accept;
  logic               out_hs;
  logic [LANES*K-1:0] red_d;
  logic [LANES-1:0]   nz_d;
  logic               err_d;
  logic [PW-1:0]      beat_nz_d;

  // The slot can take a new beat when empty or when it is draining this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Reduce every lane against the current B and flag nonzero results
  always_comb begin
    red_d = '0;
    nz_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      red_d[l*K +: K] = reduce_word(in_data[l*W +: K], in_data[l*W+K +: D], b_q);
      nz_d[l]         = |red_d[l*K +: K];
    end
  end

  // Frame position, frame mode (live on the first beat, latched afterwards),
  // and the per-beat error contribution under that mode
  always_comb begin
    last_d    = (beat_q == LAST_BEAT);
    beat_d    = last_d ? '0 : beat_q + BW'(1);
    mode_d    = (beat_q == '0) ? mode : mode_q;
    err_d     = mode_d & (|nz_d);
    beat_nz_d = mode_d ? popcount(nz_d) : '0;
    acc_d     = acc_q + CW'(beat_nz_q);
  end

  // B row writes; addresses beyond D-1 match no row and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
    end else begin
      for (int j = 0; j < D; j++) begin
        if (b_we && (b_waddr == AW'(j))) begin
          b_q[j] <= b_wdata;
        end
      end
    end
  end

  // Beat counter and frame mode advance on every accepted input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      beat_q <= beat_d;
      mode_q <= mode_d;
    end
  end

  // Single output slot: load on accept, empty when drained with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      beat_nz_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= red_d;
      out_last_q  <= last_d;
      out_err_q   <= err_d;
      beat_nz_q   <= beat_nz_d;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Accumulate nonzero lanes per frame; publish and clear on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q           <= '0;
      frame_err_cnt_q <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (out_hs) begin
        if (out_last_q) begin
          frame_err_cnt_q <= acc_d;
          frame_done_q    <= 1'b1;
          acc_q           <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

  // Sticky alarm; a new error handshake takes priority over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (out_hs && out_err_q) begin
      alarm_q <= 1'b1;
    end else if (alarm_clr) begin
      alarm_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_err       = out_err_q;
  assign frame_done    = frame_done_q;
  assign frame_err_cnt = frame_err_cnt_q;
  assign alarm         = alarm_q;

endmodule

// File: tb/tb_mod_p_stream.sv
// tb_mod_p_stream: directed scenarios plus randomized streaming, checked every
// cycle against a transaction-level reference model of mod_p_stream.
module tb_mod_p_stream;

  localparam int K         = 8;
  localparam int D         = 8;
  localparam int LANES     = 4;
  localparam int FRAME_LEN = 4;
  localparam int W         = K + D;
  localparam int AW        = $clog2(D);
  localparam int CW        = $clog2(FRAME_LEN*LANES+1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_data;
  logic                 mode;
  logic                 b_we;
  logic [AW-1:0]        b_waddr;
  logic [K-1:0]         b_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*K-1:0]   out_data;
  logic                 out_last;
  logic                 out_err;
  logic                 frame_done;
  logic [CW-1:0]        frame_err_cnt;
  logic                 alarm;
  logic                 alarm_clr;

  mod_p_stream #(.K(K), .D(D), .LANES(LANES), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .b_we(b_we), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .frame_done(frame_done),
    .frame_err_cnt(frame_err_cnt), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [K-1:0]       mB [D];
  bit                 m_valid;
  logic [LANES*K-1:0] m_data;
  bit                 m_last, m_err, m_mode, m_done, m_alarm;
  int                 m_nz, m_beat, m_acc, m_fcnt;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Residue of one word: x xor every B row selected by a set y bit
  function automatic logic [K-1:0] ref_reduce(input logic [K-1:0] x, input logic [D-1:0] y);
    logic [K-1:0] r;
    r = x;
    for (int j = 0; j < D; j++) if (y[j]) r ^= mB[j];
    return r;
  endfunction

  function automatic logic [LANES*W-1:0] all_lanes(input logic [K-1:0] x, input logic [D-1:0] y);
    logic [LANES*W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = {y, x};
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < D; j++) mB[j] = '0;
    m_valid = 0; m_data = '0; m_last = 0; m_err = 0; m_mode = 0;
    m_done = 0; m_alarm = 0; m_nz = 0; m_beat = 0; m_acc = 0; m_fcnt = 0;
  endtask

  task automatic model_edge();
    bit hs, acc_b;
    int nzc;
    logic [K-1:0] r;
    hs    = m_valid && out_ready;
    acc_b = in_valid && (!m_valid || out_ready);
    m_done = 0;
    if (hs) begin
      if (m_last) begin
        m_fcnt = m_acc + m_nz;
        m_acc  = 0;
        m_done = 1;
      end else begin
        m_acc += m_nz;
      end
    end
    if (hs && m_err) m_alarm = 1;
    else if (alarm_clr) m_alarm = 0;
    if (acc_b) begin
      if (m_beat == 0) m_mode = mode;
      nzc = 0;
      for (int l = 0; l < LANES; l++) begin
        r = ref_reduce(in_data[l*W +: K], in_data[l*W+K +: D]);
        m_data[l*K +: K] = r;
        if (r != 0) nzc++;
      end
      m_err   = m_mode && (nzc > 0);
      m_nz    = m_mode ? nzc : 0;
      m_last  = (m_beat == FRAME_LEN-1);
      m_beat  = (m_beat + 1) % FRAME_LEN;
      m_valid = 1;
    end else if (hs) begin
      m_valid = 0;
    end
    if (b_we && int'(b_waddr) < D) mB[b_waddr] = b_wdata;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_last", out_last, m_last);
      chk("out_err", out_err, m_err);
    end
    chk("frame_done", frame_done, m_done);
    chk("frame_err_cnt", frame_err_cnt, m_fcnt);
    chk("alarm", alarm, m_alarm);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_err"}, out_err, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_cnt"}, frame_err_cnt, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  // Called just after a falling edge with inputs already set
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; b_we = 0; alarm_clr = 0; out_ready = 1;
  endtask

  task automatic send(input logic [LANES*W-1:0] data, input logic md);
    in_valid = 1; in_data = data; mode = md;
    cycle();
    in_valid = 0;
  endtask

  task automatic write_b(input int row, input logic [K-1:0] val);
    b_we = 1; b_waddr = AW'(row); b_wdata = val;
    cycle();
    b_we = 0;
  endtask

  task automatic reset_now(input string tag);
    rst_n = 0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [LANES*W-1:0] v;
  logic [LANES*K-1:0] saved;
  logic [K-1:0]       xr;
  logic [D-1:0]       yr;

  initial begin
    rst_n = 0; in_data = '0; mode = 0; b_waddr = '0; b_wdata = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1;
    @(negedge clk);

    // B = 0, REDUCE: every lane passes x through
    for (int b = 0; b < FRAME_LEN; b++) begin
      send(all_lanes(8'h5A, 8'hFF), 1'b0);
      chk("t1_data", out_data, {LANES{8'h5A}});
      chk("t1_last", out_last, b == FRAME_LEN-1);
      chk("t1_err", out_err, 0);
    end
    cycle();
    chk("t1_done", frame_done, 1);
    chk("t1_cnt", frame_err_cnt, 0);

    // Row 0 only: y bit 0 folds in, y bit 1 does not yet
    write_b(0, 8'h01);
    send(all_lanes(8'h00, 8'h01), 1'b0);
    chk("t2_r01", out_data, {LANES{8'h01}});
    send(all_lanes(8'h00, 8'h02), 1'b0);
    chk("t2_r00", out_data, {LANES{8'h00}});
    send(all_lanes(8'h33, 8'h00), 1'b0);
    send(all_lanes(8'h44, 8'h00), 1'b0);

    // Identity B, CHECK frame with a single bad lane in beat 2
    for (int j = 0; j < D; j++) write_b(j, 8'h01 << j);
    for (int b = 0; b < FRAME_LEN; b++) begin
      for (int l = 0; l < LANES; l++) begin
        yr = D'($urandom);
        xr = yr;
        if (b == 2 && l == 1) xr = yr ^ 8'h10;
        v[l*W +: W] = {yr, xr};
      end
      send(v, 1'b1);
      chk("t3_err", out_err, b == 2);
    end
    cycle();
    chk("t3_done", frame_done, 1);
    chk("t3_cnt", frame_err_cnt, 1);
    chk("t3_alarm", alarm, 1);
    repeat (3) cycle();
    chk("t3_alarm_hold", alarm, 1);

    // Backpressure mid-frame
    send(all_lanes(8'h0F, 8'h03), 1'b1);
    send(all_lanes(8'hF0, 8'h30), 1'b1);
    saved = out_data;
    in_valid = 1; in_data = all_lanes(8'h11, 8'h11); out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", out_data, saved);
    end
    out_ready = 1;
    cycle();
    send(all_lanes(8'h22, 8'h20), 1'b1);
    cycle();
    chk("bp_done", frame_done, 1);

    // B write in the same cycle as an accepted beat
    b_we = 1; b_waddr = '0; b_wdata = 8'hFF;
    send(all_lanes(8'h00, 8'h01), 1'b0);
    b_we = 0;
    chk("wr_old", out_data, {LANES{8'h01}});
    send(all_lanes(8'h00, 8'h01), 1'b0);
    chk("wr_new", out_data, {LANES{8'hFF}});
    send(all_lanes(8'h00, 8'h00), 1'b0);
    send(all_lanes(8'h00, 8'h00), 1'b0);

    // Clear and set alarm in the same cycle
    alarm_clr = 1; cycle(); alarm_clr = 0;
    chk("clr_alone", alarm, 0);
    write_b(0, 8'h01);
    send(all_lanes(8'h05, 8'h04), 1'b1);
    alarm_clr = 1;
    send(all_lanes(8'h08, 8'h08), 1'b1);
    alarm_clr = 0;
    chk("set_wins", alarm, 1);
    send(all_lanes(8'h08, 8'h08), 1'b1);
    send(all_lanes(8'h08, 8'h08), 1'b1);
    cycle();
    chk("clr_frame_cnt", frame_err_cnt, LANES);

    // Reset after beat 2 of a frame
    send(all_lanes(8'h12, 8'h34), 1'b0);
    send(all_lanes(8'h56, 8'h78), 1'b0);
    reset_now("mid_rst");
    for (int b = 0; b < FRAME_LEN; b++) begin
      send(all_lanes(8'hC3, 8'hA5), 1'b0);
      chk("post_rst_data", out_data, {LANES{8'hC3}});
      chk("post_rst_last", out_last, b == FRAME_LEN-1);
    end
    cycle();

    // Randomized streaming
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      b_we      = ($urandom_range(0, 9) == 0);
      b_waddr   = AW'($urandom_range(0, D-1));
      b_wdata   = K'($urandom);
      alarm_clr = ($urandom_range(0, 19) == 0);
      for (int l = 0; l < LANES; l++) begin
        yr = D'($urandom);
        xr = ($urandom_range(0, 2) == 0) ? ref_reduce('0, yr) : K'($urandom);
        in_data[l*W +: W] = {yr, xr};
      end
      if (i == 1500) begin
        idle_inputs();
        reset_now("rnd_rst");
      end else begin
        cycle();
      end
    end

    idle_inputs();
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_p_stream.md
# mod_p_stream

Streaming, multi-lane successor to the combinational mod-P reducer in the CLM datapath. Each beat carries LANES encoded words of K data bits plus D redundancy bits. Every word is reduced modulo P through a runtime-loadable D×K matrix B, and the reduced K-bit values leave through a registered valid/ready stage. In CHECK mode the block also treats any nonzero reduction as an invalid codeword, and keeps per-frame error counts plus a sticky alarm for the fault-detection logic.

## Interface
- K, 8, data bits per word (output width per lane)
- D, 8, redundancy bits per word (rows of B)
- LANES, 4, words per beat
- FRAME_LEN, 4, beats per frame (≥1)
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, input beat valid
- in_ready, out, 1, input beat accepted when in_valid && in_ready
- in_data, in, LANES*(K+D), lane l at [l*(K+D) +: K+D]; low K bits = x, upper D bits = y
- mode, in, 1, 0 = REDUCE, 1 = CHECK; sampled on the first accepted beat of each frame
- b_we, in, 1, write one row of B
- b_waddr, in, $clog2(D), row index j
- b_wdata, in, K, row j contents; bit i = B[j][i]
- out_valid, out, 1, output beat valid
- out_ready, in, 1, downstream accepts when out_valid && out_ready
- out_data, out, LANES*K, reduced words, lane l at [l*K +: K]
- out_last, out, 1, marks the last beat of a frame
- out_err, out, 1, CHECK mode only: some lane of this beat reduced to nonzero
- frame_done, out, 1, one-cycle pulse when the last beat of a frame is accepted downstream
- frame_err_cnt, out, $clog2(FRAME_LEN*LANES+1), count of nonzero lanes in the completed frame (CHECK mode); 0 in REDUCE mode
- alarm, out, 1, sticky: set by any out_err handshake
- alarm_clr, in, 1, clears alarm

## Operation
- Per-lane reduction: r[i] = x[i] ^ XOR over j of (B[j][i] & y[j]), for i in 0..K-1.
- B is a register bank of D rows by K bits. All rows reset to 0, which makes r = x.
- A B write takes effect from the next cycle. A beat accepted in the same cycle as a write uses the old B.
- b_waddr ≥ D: the write is ignored.
- Output register stage is a single slot:
  - in_ready = !out_valid || out_ready.
  - On acceptance, the slot loads r for every lane, out_last, and out_err.
  - If nothing is accepted while the slot is being drained, out_valid falls to 0.
- Beat counter runs 0..FRAME_LEN-1 and advances on each input acceptance.
  - out_last = (counter == FRAME_LEN-1) at acceptance; the counter then wraps to 0.
  - FRAME_LEN = 1: every beat is last.
- Frame mode is latched when a beat is accepted with counter == 0 and holds for the rest of the frame. Mode changes mid-frame are ignored.
- CHECK mode:
  - Per lane, nz_l = (r_l != 0).
  - out_err = OR of nz_l.
  - The error accumulator adds the popcount of nz_l on each output handshake.
  - On the handshake of an out_last beat, frame_err_cnt loads the accumulator value including that beat, frame_done pulses, and the accumulator clears.
- REDUCE mode: out_err = 0, the accumulator does not count, and frame_err_cnt loads 0 at frame end.
- Alarm:
  - Set on any handshake with out_err = 1.
  - alarm_clr clears it.
  - Set and clear in the same cycle: set wins.
- Reset (any time, including mid-frame) clears everything below; the next accepted beat starts a fresh frame.
  - All outputs go to 0: out_valid, out_data, out_last, out_err, frame_done, frame_err_cnt, alarm.
  - in_ready is 1 after reset.
  - Beat counter, accumulator, latched mode and B are all cleared.

## Timing
- Latency is 1 cycle: a beat accepted at edge n is visible on out_* after edge n.
- Throughput is 1 beat/cycle while out_ready = 1.
- Backpressure:
  - out_valid and out_data hold stable while out_ready = 0.
  - in_ready drops in the same cycle, combinationally from out_ready.
- frame_done and frame_err_cnt update on the edge after the last beat's output handshake.
- frame_err_cnt holds until the next frame completes.
- alarm updates one edge after the triggering handshake.

## Test plan
- Reset then stream, B = 0, REDUCE mode, lane words {y=8'hFF, x=8'h5A} -> out_data lanes = 8'h5A after 1 cycle; out_err = 0; out_last on beat 4; frame_done with frame_err_cnt = 0.
- Write B row 0 = 8'h01, then send x=8'h00, y=8'h01 -> r = 8'h01. Same beat with y=8'h02 -> r = 8'h00 (row 1 is still 0).
- Load B (row j = 8'h01<<j), CHECK mode, 4-beat frame with lanes x=y (all reduce to 0) except one lane in beat 2 with x ^ y = 8'h10 -> out_err = 1 on beat 2 only; frame_err_cnt = 1; alarm = 1 and stays set.
- Backpressure: hold out_ready = 0 for 3 cycles mid-frame -> in_ready = 0, output stable, no beats lost or duplicated; counts unchanged.
- Same cycle: b_we plus an accepted beat -> that beat uses the old B, the next beat uses the new B. Same cycle: alarm_clr plus an out_err handshake -> alarm stays 1.
- Assert rst_n low after beat 2 of a frame -> all outputs 0 immediately; the next frame's 4th beat (not its 2nd) carries out_last; B is back to 0.
